// File: rtl/mix_columns_seq.sv
// AES MixColumns stage, processing COLS_PER_CYCLE columns per clock with a valid/ready handshake on each side.
// Define MIX_COLUMNS_INV_EN to add the inv_mode port and the InvMixColumns datapath.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         last_round,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         inv_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned STEPS     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LAST_STEP = 2'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t        state;
    logic [1:0]    step;
    logic [127:0]  data;
    logic [31:0]   mixed [4];
    logic [3:0]    sel;
`ifdef MIX_COLUMNS_INV_EN
    logic          inv_r;
`endif

    function automatic logic [7:0] x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    function automatic logic [7:0] m9(input logic [7:0] b);
        return x2(x2(x2(b))) ^ b;
    endfunction
    function automatic logic [7:0] mb(input logic [7:0] b);
        return x2(x2(x2(b))) ^ x2(b) ^ b;
    endfunction
    function automatic logic [7:0] md(input logic [7:0] b);
        return x2(x2(x2(b))) ^ x2(x2(b)) ^ b;
    endfunction
    function automatic logic [7:0] me(input logic [7:0] b);
        return x2(x2(x2(b))) ^ x2(x2(b)) ^ x2(b);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
    endfunction
`endif

    // Column i belongs to the window updated on step i / COLS_PER_CYCLE.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            sel[i] = (2'(i / COLS_PER_CYCLE) == step);
`ifdef MIX_COLUMNS_INV_EN
            mixed[i] = inv_r ? inv_col(data[127-32*i -: 32]) : fwd_col(data[127-32*i -: 32]);
`else
            mixed[i] = fwd_col(data[127-32*i -: 32]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            data      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data     <= in_data;
                        step     <= '0;
                        in_ready <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
                        inv_r    <= inv_mode;
`endif
                        if (last_round) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (sel[i]) data[127-32*i -: 32] <= mixed[i];
                    end
                    if (step == LAST_STEP) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        step      <= '0;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data = data;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) checked every cycle against a transaction model.
// Define MIX_COLUMNS_INV_EN to also exercise the inverse transform.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         last_round;
    logic         inv_mode;
    logic         out_ready;
    logic [2:0]   rdy;
    logic [2:0]   vld;
    logic [127:0] od [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .last_round(last_round),
`ifdef MIX_COLUMNS_INV_EN
        .inv_mode(inv_mode),
`endif
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(od[0]));

    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .last_round(last_round),
`ifdef MIX_COLUMNS_INV_EN
        .inv_mode(inv_mode),
`endif
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(od[1]));

    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .last_round(last_round),
`ifdef MIX_COLUMNS_INV_EN
        .inv_mode(inv_mode),
`endif
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(od[2]));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] d, input logic inv);
        logic [7:0]   m [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gf_mul(m[(j - row + 4) % 4], d[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    int           cpc [3] = '{1, 2, 4};
    int           ph  [3] = '{0, 0, 0};   // 0 waiting for a word, 1 computing, 2 result presented
    int           cnt [3] = '{0, 0, 0};
    logic [127:0] exp_d [3];
    bit           zero_ok [3] = '{0, 0, 0};
    bit           chk_en = 0;
    int           obs_xfer [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && vld[k] && out_ready) obs_xfer[k]++;
            if (rst) begin
                ph[k] = 0; zero_ok[k] = 1; exp_d[k] = '0;
            end else if (ph[k] == 0) begin
                if (in_valid) begin
                    zero_ok[k] = 0;
                    if (last_round) begin
                        ph[k] = 2; exp_d[k] = in_data;
                    end else begin
                        ph[k] = 1; cnt[k] = 4 / cpc[k];
`ifdef MIX_COLUMNS_INV_EN
                        exp_d[k] = mix_model(in_data, inv_mode);
`else
                        exp_d[k] = mix_model(in_data, 1'b0);
`endif
                    end
                end
            end else if (ph[k] == 1) begin
                cnt[k]--;
                if (cnt[k] == 0) ph[k] = 2;
            end else if (out_ready) begin
                ph[k] = 0;
            end
        end
        if (rst) chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model in_ready[%0d]", k), 128'(rdy[k]), 128'(ph[k] == 0));
                check($sformatf("model out_valid[%0d]", k), 128'(vld[k]), 128'(ph[k] == 2));
                if (ph[k] == 2 || zero_ok[k])
                    check($sformatf("model out_data[%0d]", k), od[k], exp_d[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int lat [3];

    task automatic send(input logic [127:0] d, input logic lr, input logic inv, input bit noisy);
        bit done;
        @(negedge clk);
        in_data = d; last_round = lr; inv_mode = inv; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) lat[k] = vld[k] ? 0 : -1;
        @(negedge clk);
        if (!noisy) in_valid = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        last_round = ~lr; inv_mode = ~inv;
        for (int n = 1; n <= 20; n++) begin
            done = 1;
            for (int k = 0; k < 3; k++) if (lat[k] < 0) done = 0;
            if (done) break;
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) if (lat[k] < 0 && vld[k]) lat[k] = n;
        end
        for (int k = 0; k < 3; k++) begin
            if (lat[k] < 0) begin
                tests++; fails++;
                $display("FAIL latency[%0d]: out_valid never rose within 20 cycles", k);
            end else begin
                check($sformatf("latency[%0d]", k), 128'(lat[k]), lr ? 128'd0 : 128'(4 / cpc[k]));
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
        check("in_ready after release", 128'(rdy), 128'(3'b111));
    endtask

    localparam logic [127:0] VA  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VAX = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VB  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] VF  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] VFX = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    initial begin
        logic [127:0] snap;
        int words;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; last_round = 1'b0; inv_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", 128'(rdy), 128'(3'b111));
        check("reset out_valid", 128'(vld), 128'(3'b000));
        for (int k = 0; k < 3; k++) check($sformatf("reset out_data[%0d]", k), od[k], '0);

        send(VA, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) check($sformatf("vecA[%0d]", k), od[k], VAX);
        release_out();

        send(VB, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) check($sformatf("bypass[%0d]", k), od[k], VB);
        release_out();

        // Result must survive a 10-cycle stall with new words offered upstream.
        send(VF, 1'b0, 1'b0, 1'b1);
        snap = od[0];
        repeat (10) begin
            @(negedge clk);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            check("stall in_ready", 128'(rdy), 128'(3'b000));
            check("stall out_data", od[0], snap);
        end
        for (int k = 0; k < 3; k++) check($sformatf("vecF[%0d]", k), od[k], VFX);
        release_out();

        // Reset in the second computing cycle of the one-column instance.
        @(negedge clk);
        in_data = VA; last_round = 1'b0; inv_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("midreset out_data", od[0], '0);
        check("midreset in_ready", 128'(rdy[0]), 128'd1);
        check("midreset out_valid", 128'(vld), 128'(3'b000));
        repeat (6) @(negedge clk);
        check("midreset stays idle", 128'(vld), 128'(3'b000));

        send(VA, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) check($sformatf("post-reset vecA[%0d]", k), od[k], VAX);
        release_out();
        words = 4;

`ifdef MIX_COLUMNS_INV_EN
        send(VAX, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) check($sformatf("inverse[%0d]", k), od[k], VA);
        release_out();
        words++;
`endif

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("output transfers[%0d]", k), 128'(obs_xfer[k]), 128'(words));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
